// File: rtl/oled_bus_responder.sv
// Device-side emulation of the WEH001602A 8-bit parallel bus: instruction decode,
// 128-byte DDRAM, graphics-mode pixel writes and status/data read-back.
module oled_bus_responder #(
    parameter int BUSY_CYCLES = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rs_pin,
    input  logic       read_pin,
    input  logic       enable_pin,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    output logic       db_oe,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       display_on,
    output logic       graphics_mode,
    output logic       power_on,
    output logic       pixel_strobe,
    output logic [6:0] pixel_x,
    output logic       pixel_y,
    output logic [7:0] pixel_data,
    output logic       protocol_err
);
    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    localparam int            CW        = $clog2(BUSY_CYCLES + 1);
    localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYCLES);

    logic [SYNC_STAGES-1:0][10:0] sync_q;
    logic       rs_s, rw_s, e_s;
    logic [7:0] db_s;
    logic       e_prev_q, cap_rs_q, cap_rw_q;
    logic [7:0] cap_db_q;

    state_t        state_q, state_d;
    logic [6:0]    fill_q, fill_d, ac_q, ac_d, ac_step;
    logic          id_q, id_d, cg0_q, cg0_d, disp_q, disp_d;
    logic          gfx_q, gfx_d, pwr_q, pwr_d, err_q, err_d;
    logic [CW-1:0] busy_cnt_q, busy_cnt_d;
    logic          pix_stb_q, pix_stb_d, pix_y_q, pix_y_d;
    logic [6:0]    pix_x_q, pix_x_d;
    logic [7:0]    pix_data_q, pix_data_d;
    logic [7:0]    db_out_q, prefetch_q, rd_data_q;
    logic [7:0]    ddram_q [128];

    logic       exec, wr_exec, rd_exec, busy, start_clear;
    logic       fill_we, fill_done, dwr_we, mem_we;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata;

    assign {rs_s, rw_s, e_s, db_s} = sync_q[SYNC_STAGES-1];
    assign exec        = e_prev_q & ~e_s;
    assign wr_exec     = exec & ~cap_rw_q;
    assign rd_exec     = exec & cap_rw_q;
    assign busy        = (busy_cnt_q != '0) || (state_q == ST_CLEAR);
    assign start_clear = wr_exec & ~busy & ~cap_rs_q & (cap_db_q == 8'h01);
    assign ac_step     = id_q ? ac_q + 7'd1 : ac_q - 7'd1;

    // NOTE: every clocked process uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            e_prev_q <= 1'b0;
            cap_rs_q <= 1'b0;
            cap_rw_q <= 1'b0;
            cap_db_q <= 8'h00;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], {rs_pin, read_pin, enable_pin, db_in}};
            e_prev_q <= e_s;
            if (e_s) begin
                cap_rs_q <= rs_s;
                cap_rw_q <= rw_s;
                cap_db_q <= db_s;
            end
        end
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        ac_d       = ac_q;
        id_d       = id_q;
        cg0_d      = cg0_q;
        disp_d     = disp_q;
        gfx_d      = gfx_q;
        pwr_d      = pwr_q;
        err_d      = err_q;
        busy_cnt_d = (busy_cnt_q != '0) ? busy_cnt_q - 1'b1 : busy_cnt_q;
        pix_stb_d  = 1'b0;
        pix_x_d    = pix_x_q;
        pix_y_d    = pix_y_q;
        pix_data_d = pix_data_q;
        dwr_we     = 1'b0;
        fill_d     = fill_we ? fill_q + 7'd1 : 7'd0;
        if (wr_exec && busy) begin
            err_d = 1'b1;
        end else if (wr_exec && cap_rs_q) begin
            if (gfx_q) begin
                pix_stb_d  = 1'b1;
                pix_x_d    = ac_q;
                pix_y_d    = cg0_q;
                pix_data_d = cap_db_q;
            end else begin
                dwr_we = 1'b1;
            end
            ac_d       = ac_step;
            busy_cnt_d = BUSY_LOAD;
        end else if (wr_exec) begin
            if (cap_db_q != 8'h00) busy_cnt_d = BUSY_LOAD;
            casez (cap_db_q)
                8'b1???????: ac_d  = cap_db_q[6:0];
                8'b01??????: cg0_d = cap_db_q[0];
                8'b001?????: ;
                8'b0001????: begin
                    gfx_d = cap_db_q[3];
                    pwr_d = cap_db_q[2];
                end
                8'b00001???: disp_d = cap_db_q[2];
                8'b000001??: id_d   = cap_db_q[1];
                8'b0000001?: ac_d   = 7'd0;
                default:     ;
            endcase
        end else if (rd_exec && cap_rs_q) begin
            ac_d = ac_step;
        end
        // The fill's last cell restores the pointer and starts the trailing busy window.
        if (fill_done) begin
            ac_d       = 7'd0;
            id_d       = 1'b1;
            busy_cnt_d = BUSY_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fill_q     <= 7'd0;
            ac_q       <= 7'd0;
            id_q       <= 1'b1;
            cg0_q      <= 1'b0;
            disp_q     <= 1'b0;
            gfx_q      <= 1'b0;
            pwr_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_cnt_q <= '0;
            pix_stb_q  <= 1'b0;
            pix_x_q    <= 7'd0;
            pix_y_q    <= 1'b0;
            pix_data_q <= 8'h00;
            db_out_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            ac_q       <= ac_d;
            id_q       <= id_d;
            cg0_q      <= cg0_d;
            disp_q     <= disp_d;
            gfx_q      <= gfx_d;
            pwr_q      <= pwr_d;
            err_q      <= err_d;
            busy_cnt_q <= busy_cnt_d;
            pix_stb_q  <= pix_stb_d;
            pix_x_q    <= pix_x_d;
            pix_y_q    <= pix_y_d;
            pix_data_q <= pix_data_d;
            db_out_q   <= rs_s ? prefetch_q : {busy, ac_q};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_clear) state_d = ST_CLEAR;
            ST_CLEAR: if (fill_q == 7'h7F) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fill_we   = (state_q == ST_CLEAR);
        fill_done = fill_we && (fill_q == 7'h7F);
        mem_we    = fill_we | dwr_we;
        mem_addr  = fill_we ? fill_q : ac_q;
        mem_wdata = fill_we ? 8'h20 : cap_db_q;
    end

    // NOTE: DDRAM has no reset; contents survive reset, including a partially completed clear.
    always_ff @(posedge clk) begin
        if (mem_we) ddram_q[mem_addr] <= mem_wdata;
        prefetch_q <= ddram_q[ac_q];
        rd_data_q  <= ddram_q[rd_addr];
    end

    assign db_oe         = rw_s & e_s;
    assign db_out        = db_out_q;
    assign rd_data       = rd_data_q;
    assign display_on    = disp_q;
    assign graphics_mode = gfx_q;
    assign power_on      = pwr_q;
    assign pixel_strobe  = pix_stb_q;
    assign pixel_x       = pix_x_q;
    assign pixel_y       = pix_y_q;
    assign pixel_data    = pix_data_q;
    assign protocol_err  = err_q;
endmodule

// File: doc/oled_bus_responder.md
Name: oled_bus_responder

Overview:
- Device-side end of the WEH001602A 8-bit parallel bus (RS, R/!W, E, DB[7:0]); emulates the OLED controller as seen by a host driver.
- Decodes instructions, holds a 128-byte DDRAM, emits graphics-mode pixel writes, and answers status and data reads.
- Sits behind the board pins for hardware-in-loop testing of host drivers; also serves as the bench model for them.

Parameters:
- BUSY_CYCLES, 16, clk cycles busy flag stays set after any executed instruction or data write.
- SYNC_STAGES, 2, synchroniser depth on rs_pin, read_pin, enable_pin and db_in; allowed values 2..3.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- rs_pin  in  1  register select from host (0 = instruction/status, 1 = data).
- read_pin  in  1  R/!W from host (1 = read).
- enable_pin  in  1  E strobe from host.
- db_in  in  8  DB pins as driven by host.
- db_out  out  8  DB value when responder drives.
- db_oe  out  1  DB output enable (tristate control at top level).
- rd_addr  in  7  inspection read address into DDRAM.
- rd_data  out  8  DDRAM[rd_addr], registered, 1-cycle latency.
- display_on  out  1  display on/off state.
- graphics_mode  out  1  G/C bit from the last mode/power instruction.
- power_on  out  1  PWR bit from the last mode/power instruction.
- pixel_strobe  out  1  one-cycle pulse per graphics-mode data write.
- pixel_x  out  7  DDRAM address at the time of the pixel write.
- pixel_y  out  1  CGRAM address bit 0 at the time of the pixel write.
- pixel_data  out  8  written byte.
- protocol_err  out  1  sticky; set when a write arrives while busy.

Behaviour:
- Synchronisation: every pin input passes through SYNC_STAGES flops. While synced E = 1, sample synced RS, R/!W and DB into a capture register every cycle. A synced E falling edge (1 then 0) is the execute event and uses the last captured values.
- Reads:
  - db_oe = synced R/!W & synced E.
  - Status read (RS = 0): db_out = {busy, AC[6:0]}.
  - Data read (RS = 1): db_out = prefetch register holding DDRAM[AC]. Prefetch refreshes 1 cycle after any AC or DDRAM change.
  - Read data is valid on db_out SYNC_STAGES+1 clk after E rises at the pin.
- Write decode (RS = 0, R/!W = 0); highest set bit wins:
  - 1xxxxxxx: AC = db[6:0], address mode = DDRAM.
  - 01xxxxxx: CGRAM addr = db[5:0], address mode = CGRAM.
  - 001xxxxx: function set; accepted, no state change.
  - 0001GPxx: graphics_mode = G, power_on = P.
  - 00001Dxx: display_on = D.
  - 000001IS: ID = I; S is ignored.
  - 0000001x: AC = 0.
  - 00000001: clear.
  - 00000000: no operation, and no busy.
- Clear: enter CLEAR state. Write 0x20 to DDRAM[0..127], one address per cycle (128 cycles), then AC = 0, ID = 1, then BUSY_CYCLES of busy. busy = 1 throughout.
- Data write (RS = 1, R/!W = 0):
  - graphics_mode = 1: pulse pixel_strobe with pixel_x = AC, pixel_y = CGRAM[0], pixel_data = db. DDRAM is untouched.
  - graphics_mode = 0: DDRAM[AC] = db.
  - In both cases AC then steps by ±1 per ID.
- Data read: AC steps on the E falling edge of the read.
- AC wrap: AC is 7 bits. Increment wraps 0x7F to 0x00; decrement wraps 0x00 to 0x7F.
- Busy:
  - Counter loads BUSY_CYCLES on each executed non-NOP instruction or data write; busy = counter != 0 or state == CLEAR.
  - A write while busy is dropped and sets protocol_err; only reset clears it.
  - Reads are always served, including while busy.
- States: IDLE, CLEAR. An E falling edge during CLEAR is handled as a write while busy (dropped, protocol_err set).
- Reset values:
  - Outputs: db_oe = 0, db_out = 0, display_on = 0, graphics_mode = 0, power_on = 0, pixel_strobe = 0, pixel_x = 0, pixel_y = 0, pixel_data = 0, protocol_err = 0.
  - Internal: AC = 0, ID = 1, CGRAM addr = 0, busy counter = 0, synchronisers cleared.
  - DDRAM contents are not reset.
- Reset mid-CLEAR aborts the fill; already-written cells stay 0x20.

Test Plan:
- Reset, then write 0x80 | 0x05, wait for busy to drop, write data 0x41, 0x42 -> DDRAM[5] = 0x41, DDRAM[6] = 0x42; status read returns 0x07 once idle; returns 0x87 if read within BUSY_CYCLES of the write.
- Write 0x04 (ID = 0), 0x80, then data 0x55 -> DDRAM[0] = 0x55, AC = 0x7F. Write 0x06 (ID = 1), 0xFF, then data 0x66 -> DDRAM[0x7F] = 0x66, AC = 0x00.
- Write 0x1F, 0x41, 0x80, then data 0xAA, 0x0F -> two pixel_strobe pulses: (x = 0, y = 1, 0xAA), (x = 1, y = 1, 0x0F); DDRAM unchanged.
- Write 0x01, then poll status -> busy for ≥128 + BUSY_CYCLES cycles; afterwards rd_data = 0x20 for rd_addr 0, 63, 127, and status = 0x00.
- Issue a data write 2 cycles after the previous instruction finishes executing -> write dropped, protocol_err = 1 and stays set until reset.
- Start clear, assert reset at fill address 10 for 1 cycle -> busy = 0 and AC = 0 right after; DDRAM[0..9] = 0x20; db_oe = 0.
